hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Shared controller for the eight DE2-115 seven-segment displays (HEX0–HEX7). Two independent requesters write nibble values and per-digit attributes (blank, blink) through a valid/ack handshake, arbitrated round-robin. The block holds the digit state, applies a global blink phase, decodes each digit to active-low segments and drives registered HEX outputs straight to board pins.

## Interface
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz); must be ≥ 2; counter width is $clog2(BLINK_DIV).
- clk  in  1  system clock, CLOCK_50 domain
- resetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  write request from requester 0 / 1
- idx0 / idx1  in  3  target digit (0 = HEX0 … 7 = HEX7)
- val0 / val1  in  4  hex value to display
- blank0 / blank1  in  1  1 = digit dark
- blink0 / blink1  in  1  1 = digit blinks
- ack0 / ack1  out  1  write accepted this cycle (combinational grant)
- clear_all  in  1  synchronous clear of all digit state
- HEX0 … HEX7  out  7 each  segments {g,f,e,d,c,b,a}, active-low, registered

## Operation
- Digit state: 8 entries × {val[3:0], blank, blink}.
- Handshake:
  - A requester holds req high with a stable payload until ack.
  - ack is asserted combinationally in the cycle of acceptance. The payload is written at that rising edge.
  - At most one ack per cycle.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: grant goes to the requester selected by priority pointer `prio`.
  - After any grant, `prio` points to the non-granted requester.
  - `prio` resets to requester 0.
- clear_all:
  - Sets every entry to {0, blank=1, blink=0}.
  - Wins over any request: no ack that cycle, and `prio` is unchanged.
- Blink:
  - A free-running counter runs 0…BLINK_DIV−1. On wrap, `phase` toggles.
  - A digit is shown dark when blank=1, or when (blink=1 and phase=1).
- Decode (value → {g..a}):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
  - Dark digit → 1111111.
- Writes to the same index on consecutive cycles: the last write wins. There is no merging.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - All entries blank, val=0, blink=0.
  - HEX0–HEX7 = 7'h7F.
  - ack0/ack1 = 0.
  - prio = 0, phase = 0, blink counter = 0.
- Reset asserted mid-handshake: ack drops immediately. A request still held after release is re-arbitrated from prio = 0.
- Latency:
  - Write accepted at edge N → entry updated after edge N.
  - HEX pin reflects the new value after edge N+1 (2-cycle write-to-pin).
- Blink:
  - phase toggles exactly every BLINK_DIV cycles; the first toggle occurs BLINK_DIV cycles after reset release.
  - The HEX pin follows the phase change one cycle later.
- clear_all → all HEX = 7'h7F one cycle after the clear edge.
- A write asserted while clear_all is high stays pending and is granted in the first cycle after clear_all drops.

## Structure
- Package hex_ctrl_pkg:
  - NUM_DIGITS = 8, SEG_BLANK = 7'h7F
  - typedef digit_t {val[3:0], blank, blink}
  - the 16-entry segment constant table
- Sub-module seg7_decode: {val, dark} → 7-bit active-low segments, purely combinational, instantiated 8×.
- The top level holds the arbiter, state array, blink counter and output registers.

## Test plan
- Reset: hold resetn=0, then release. All HEX = 7F, ack0 = ack1 = 0, and no ack without a request.
- Single write: req0 with idx=3, val=A, blank=0. ack0 is high in the same cycle, and HEX3 = 0001000 two edges later. Other digits stay 7F.
- Contention:
  - req0 and req1 held continuously with different idx. Acks alternate 0,1,0,1, starting with ack0 after reset.
  - After a lone req1 grant, the next contended grant goes to req0.
- Clear collision:
  - Load all 8 digits with 0..7.
  - Assert clear_all together with req1 (idx=5, val=F). ack1 stays low and all HEX = 7F.
  - On the next cycle with clear_all low, ack1 rises and HEX5 = 0001110 two edges later.
- Blink (BLINK_DIV=4): write idx=0, val=8, blink=1. HEX0 alternates 0000000 / 1111111 every 4 cycles.
- Reset mid-operation: assert resetn=0 during a held req0. ack0 drops asynchronously and HEX = 7F. After release, req0 is re-granted at the first active edge.

Source files
------------

// File: rtl/hex_ctrl_pkg.sv
// Shared types and constants for the eight-digit seven-segment display controller.
// Segment words are {g,f,e,d,c,b,a}, active-low.
package hex_ctrl_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] val;
        logic       blank;
        logic       blink;
    } digit_t;

    // State every entry takes after reset or clear_all: dark, value 0, not blinking.
    localparam digit_t DIGIT_CLEAR = '{val: 4'h0, blank: 1'b1, blink: 1'b0};

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/hex_display_ctrl_chk.sv
// Protocol checker for the controller's grant outputs.
module hex_display_ctrl_chk (
    input logic clk,
    input logic resetn,
    input logic ack0,
    input logic ack1,
    input logic clear_all
);

    a_one_ack: assert property (@(posedge clk) disable iff (!resetn) !(ack0 && ack1));
    a_clear_blocks: assert property (@(posedge clk) disable iff (!resetn) clear_all |-> !(ack0 || ack1));

endmodule

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to active-low segment decoder with a dark override.
module seg7_decode
    import hex_ctrl_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dark,
    output logic [6:0] seg
);

    // Dark wins over the value; otherwise look the nibble up in the table.
    always_comb begin
        seg = SEG_BLANK;
        if (dark) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_lookup(val);
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Two-requester round-robin controller for eight seven-segment digits with
// per-digit blank/blink, a global blink phase and registered pin outputs.
module hex_display_ctrl
    import hex_ctrl_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0,
    input  logic [2:0] idx0,
    input  logic [3:0] val0,
    input  logic       blank0,
    input  logic       blink0,
    input  logic       req1,
    input  logic [2:0] idx1,
    input  logic [3:0] val1,
    input  logic       blank1,
    input  logic       blink1,
    output logic       ack0,
    output logic       ack1,
    input  logic       clear_all,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [6:0] HEX6,
    output logic [6:0] HEX7
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic             prio_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             wr_en_s;
    logic [2:0]       wr_idx_s;
    digit_t           wr_data_s;
    digit_t           digits_r [NUM_DIGITS];
    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;
    logic [NUM_DIGITS-1:0] dark_s;
    logic [6:0]       seg_s [NUM_DIGITS];
    logic [6:0]       hex_r [NUM_DIGITS];

    // Round-robin arbiter; prio_r names the requester favoured on contention.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (clear_all) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0 && req1) begin
            grant0_s = ~prio_r;
            grant1_s = prio_r;
        end else begin
            grant0_s = req0;
            grant1_s = req1;
        end
    end

    // Gating with resetn makes the grant vanish the instant reset asserts.
    assign ack0 = grant0_s & resetn;
    assign ack1 = grant1_s & resetn;

    // Priority pointer moves to the requester that just lost (or was idle).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_r <= 1'b0;
        end else if (grant0_s) begin
            prio_r <= 1'b1;
        end else if (grant1_s) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Select the winning payload for the state-array write port.
    always_comb begin
        wr_en_s   = grant0_s | grant1_s;
        wr_idx_s  = idx0;
        wr_data_s = '{val: val0, blank: blank0, blink: blink0};
        if (grant1_s) begin
            wr_idx_s  = idx1;
            wr_data_s = '{val: val1, blank: blank1, blink: blink1};
        end else begin
            wr_idx_s  = idx0;
            wr_data_s = '{val: val0, blank: blank0, blink: blink0};
        end
    end

    // Digit state array; clear_all outranks any granted write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_r[i] <= DIGIT_CLEAR;
            end
        end else if (clear_all) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_r[i] <= DIGIT_CLEAR;
            end
        end else if (wr_en_s) begin
            digits_r[wr_idx_s] <= wr_data_s;
        end else begin
            digits_r[wr_idx_s] <= digits_r[wr_idx_s];
        end
    end

    // Free-running blink divider; phase flips each time the count wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            phase_r <= phase_r;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign dark_s[g] = digits_r[g].blank | (digits_r[g].blink & phase_r);

        seg7_decode u_dec (
            .val  (digits_r[g].val),
            .dark (dark_s[g]),
            .seg  (seg_s[g])
        );
    end

    // Output registers drive the board pins directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_r[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_r[i] <= seg_s[i];
            end
        end
    end

    assign HEX0 = hex_r[0];
    assign HEX1 = hex_r[1];
    assign HEX2 = hex_r[2];
    assign HEX3 = hex_r[3];
    assign HEX4 = hex_r[4];
    assign HEX5 = hex_r[5];
    assign HEX6 = hex_r[6];
    assign HEX7 = hex_r[7];

    hex_display_ctrl_chk u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .ack0      (ack0),
        .ack1      (ack1),
        .clear_all (clear_all)
    );

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: acks are checked against constants in the
// grant cycle, pin values are queued with a due cycle and compared when they fall due.
module tb_hex_display_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0, req1;
    logic [2:0] idx0, idx1;
    logic [3:0] val0, val1;
    logic       blank0, blank1, blink0, blink1;
    logic       ack0, ack1;
    logic       clear_all;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [6:0] hex_w [8];

    typedef struct {
        logic [127:0] tag;
        int           due;
        int           digit;
        logic [6:0]   exp;
    } sb_t;

    sb_t sb [$];
    int  cyc = 0;
    int  rel_cyc = 0;
    int  passed = 0;
    int  total = 0;

    always #5 clk = ~clk;

    hex_display_ctrl #(.BLINK_DIV(4)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .idx0(idx0), .val0(val0), .blank0(blank0), .blink0(blink0),
        .req1(req1), .idx1(idx1), .val1(val1), .blank1(blank1), .blink1(blink1),
        .ack0(ack0), .ack1(ack1), .clear_all(clear_all),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    assign hex_w[0] = HEX0;
    assign hex_w[1] = HEX1;
    assign hex_w[2] = HEX2;
    assign hex_w[3] = HEX3;
    assign hex_w[4] = HEX4;
    assign hex_w[5] = HEX5;
    assign hex_w[6] = HEX6;
    assign hex_w[7] = HEX7;

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input logic [127:0] tag, input logic [6:0] obs, input logic [6:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %0s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Both acks as one word {ack1, ack0}, sampled after inputs settle.
    task automatic chk_acks(input logic [127:0] tag, input logic e0, input logic e1);
        #1;
        chk(tag, {5'b0, ack1, ack0}, {5'b0, e1, e0});
    endtask

    task automatic expect_hex(input logic [127:0] tag, input int digit, input logic [6:0] exp, input int due);
        sb.push_back('{tag: tag, due: due, digit: digit, exp: exp});
    endtask

    task automatic chk_all_dark(input logic [127:0] tag);
        for (int d = 0; d < 8; d++) begin
            chk(tag, hex_w[d], 7'h7F);
        end
    endtask

    // One clock: advance past the edge, then compare every pin entry now due.
    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, hex_w[sb[i].digit], sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; clear_all = 1'b0;
        req0 = 1'b0; idx0 = 3'd0; val0 = 4'h0; blank0 = 1'b0; blink0 = 1'b0;
        req1 = 1'b0; idx1 = 3'd0; val1 = 4'h0; blank1 = 1'b0; blink1 = 1'b0;
        repeat (3) tick();
        chk_all_dark("rst_hex");
        chk_acks("rst_ack", 1'b0, 1'b0);

        resetn = 1'b1;
        rel_cyc = cyc;
        chk_acks("idle_ack", 1'b0, 1'b0);
        tick();
        chk_all_dark("idle_hex");

        // Continuous contention: grants alternate starting with requester 0.
        req0 = 1'b1; idx0 = 3'd1; val0 = 4'h1;
        req1 = 1'b1; idx1 = 3'd2; val1 = 4'h2;
        for (int k = 0; k < 4; k++) begin
            chk_acks("contend", (k % 2) == 0, (k % 2) == 1);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Single write with two-edge write-to-pin latency.
        req0 = 1'b1; idx0 = 3'd3; val0 = 4'hA;
        chk_acks("wr_single", 1'b1, 1'b0);
        expect_hex("hex3_early", 3, 7'h7F, cyc + 1);
        expect_hex("hex3_A", 3, 7'b0001000, cyc + 2);
        expect_hex("hex1_val1", 1, 7'b1111001, cyc + 1);
        expect_hex("hex2_val2", 2, 7'b0100100, cyc + 1);
        expect_hex("hex0_dark", 0, 7'h7F, cyc + 2);
        expect_hex("hex5_dark", 5, 7'h7F, cyc + 2);
        tick();
        req0 = 1'b0;
        chk_acks("no_req", 1'b0, 1'b0);
        tick();

        // A lone req1 grant hands the next contended grant to requester 0.
        req1 = 1'b1; idx1 = 3'd4; val1 = 4'h4;
        chk_acks("lone1", 1'b0, 1'b1);
        expect_hex("hex4_val4", 4, exp_seg(4'h4), cyc + 2);
        tick();
        req0 = 1'b1; idx0 = 3'd6; val0 = 4'h6;
        req1 = 1'b1; idx1 = 3'd7; val1 = 4'h7;
        chk_acks("after_lone1", 1'b1, 1'b0);
        expect_hex("hex6_val6", 6, exp_seg(4'h6), cyc + 2);
        tick();
        chk_acks("contend_b", 1'b0, 1'b1);
        expect_hex("hex7_val7", 7, exp_seg(4'h7), cyc + 2);
        tick();

        // A lone req0 grant hands the next contended grant to requester 1.
        req1 = 1'b0; idx0 = 3'd5; val0 = 4'h5;
        chk_acks("lone0", 1'b1, 1'b0);
        tick();
        req1 = 1'b1; idx1 = 3'd1; val1 = 4'h3; idx0 = 3'd0; val0 = 4'h9;
        chk_acks("after_lone0", 1'b0, 1'b1);
        tick();
        req1 = 1'b0;
        chk_acks("left0", 1'b1, 1'b0);
        tick();
        req0 = 1'b0;

        // Load digits with 0..7.
        for (int i = 0; i < 8; i++) begin
            req0 = 1'b1; idx0 = 3'(i); val0 = 4'(i);
            chk_acks("load", 1'b1, 1'b0);
            expect_hex("load_hex", i, exp_seg(4'(i)), cyc + 2);
            tick();
        end
        req0 = 1'b0;

        // clear_all collides with a req1 write; the write waits one cycle.
        clear_all = 1'b1;
        req1 = 1'b1; idx1 = 3'd5; val1 = 4'hF;
        chk_acks("clr_block", 1'b0, 1'b0);
        for (int d = 0; d < 8; d++) begin
            expect_hex("clr_dark", d, 7'h7F, cyc + 2);
        end
        expect_hex("hex5_F", 5, 7'b0001110, cyc + 3);
        expect_hex("hex4_still_dark", 4, 7'h7F, cyc + 3);
        tick();
        clear_all = 1'b0;
        chk_acks("clr_pending", 1'b0, 1'b1);
        tick();
        req1 = 1'b0;
        tick();
        tick();

        // Blink with BLINK_DIV=4: phase after edge e (counted from release) is (e/4)%2.
        req0 = 1'b1; idx0 = 3'd0; val0 = 4'h8; blink0 = 1'b1;
        chk_acks("wr_blink", 1'b1, 1'b0);
        for (int d = cyc + 2; d < cyc + 14; d++) begin
            expect_hex("blink_hex0", 0, ((((d - 1 - rel_cyc) / 4) % 2) == 1) ? 7'h7F : 7'b0000000, d);
        end
        tick();
        req0 = 1'b0; blink0 = 1'b0;
        repeat (14) tick();

        // Reset in the middle of a contended handshake.
        req0 = 1'b1; idx0 = 3'd2; val0 = 4'h5;
        req1 = 1'b1; idx1 = 3'd6; val1 = 4'h9;
        chk_acks("pre_rst", 1'b0, 1'b1);
        resetn = 1'b0;
        chk_acks("rst_drop", 1'b0, 1'b0);
        chk_all_dark("rst_mid_hex");
        tick();
        tick();
        chk_acks("rst_held", 1'b0, 1'b0);
        resetn = 1'b1;
        chk_acks("post_rst", 1'b1, 1'b0);
        expect_hex("hex2_val5", 2, exp_seg(4'h5), cyc + 2);
        tick();
        req0 = 1'b0;
        chk_acks("post_rst_b", 1'b0, 1'b1);
        expect_hex("hex6_val9", 6, exp_seg(4'h9), cyc + 2);
        expect_hex("hex3_cleared", 3, 7'h7F, cyc + 2);
        tick();
        req1 = 1'b0;
        repeat (3) tick();

        chk("sb_drained", 7'(sb.size()), 7'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
